ex_alu_md: RTL and testbench
============================

Name: ex_alu_md

Overview:
- Parametrised next-generation EX-stage execution unit for the MIPS32 pipeline.
- Single-cycle ALU ops produce a registered result one cycle after issue.
- Adds an iterative multiply/divide engine with HI/LO registers, a busy/stall handshake and a flush input.
- Sits in EX, driven by ID/EX operands and the decoded ALU function; drives EX/MEM and the pipeline stall logic.

Parameters:
- WIDTH, 32, datapath width; must be even and ≥8.
- SHW, $clog2(WIDTH), shift-amount width, taken from in_dataA[SHW-1:0].

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation issued this cycle
- in_flush  input  1  abort the in-flight op and drop the result
- in_ALUFun  input  5  operation code; [4:2] group, [1:0] op
- in_dataA  input  WIDTH  operand A; shift amount for sll/srl/sra
- in_dataB  input  WIDTH  operand B
- out_valid  output  1  out_alu_result valid this cycle
- out_alu_result  output  WIDTH  registered result
- out_busy  output  1  mul/div in progress; upstream holds and new issue is refused
- out_md_done  output  1  one-cycle pulse when HI/LO are updated by mul/div
- out_hi  output  WIDTH  HI register
- out_lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, HI=LO=0, FSM=IDLE, iteration counter 0.
- Opcode map, group:op:
  - 000 arith: 00 add, 01 sub; modulo 2^WIDTH, no overflow trap.
  - 001 logic: 00 and, 01 or, 10 xor, 11 nor.
  - 010 shift: 00 sll, 01 srl, 10 lui (B<<WIDTH/2), 11 sra (arithmetic on B).
  - 011 compare: 00 slt (signed), 01 sltu; result 1 or 0, zero-extended; 10/11 result 0.
  - 100 muldiv: 00 mult, 01 multu, 10 div, 11 divu.
  - 101 hilo: 00 mfhi, 01 mflo, 10 mthi (HI<=A), 11 mtlo (LO<=A).
  - 110/111: result 0, out_valid still asserted.
- Acceptance rule: op accepted at a rising edge when in_valid=1, out_busy=0 and in_flush=0. in_valid while busy is ignored, with no side effects.
- Non-muldiv ops:
  - out_valid=1 and out_alu_result set on the cycle after acceptance.
  - mthi/mtlo update HI/LO at the acceptance edge and return A as the result.
  - mfhi/mflo return the HI/LO value at acceptance.
- out_valid is low in any cycle without a completed op. It is never held; no downstream back-pressure.
- FSM IDLE -> MUL or DIV on accepted muldiv op:
  - Operands are latched; signed variants convert to magnitudes and record the result signs.
  - out_busy=1 from the cycle after acceptance.
  - One shift-add (MUL) or restoring-subtract (DIV) step per cycle, WIDTH cycles.
  - -> FIX: apply sign correction and write HI/LO.
  - -> IDLE: out_md_done=1 for one cycle, out_busy=0.
  - Total: HI/LO visible and out_md_done high exactly WIDTH+2 cycles after the acceptance edge.
- Muldiv ops do not assert out_valid; the result is read via mfhi/mflo.
- Mult: {HI,LO} = full 2*WIDTH product.
- Div: LO=quotient (truncated toward zero), HI=remainder (sign of dividend).
- Divide by zero (div/divu): LO=all ones, HI=dividend. Completes with normal latency.
- div of most-negative by -1: LO=most-negative, HI=0.
- in_flush:
  - Highest priority. Returns the FSM to IDLE at the next edge and clears out_valid and out_busy.
  - HI/LO are left unchanged; no out_md_done.
  - An in_valid in the same cycle is not accepted.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

Decomposition:
- Package alu_md_pkg:
  - group/op localparams for the 5-bit opcode;
  - FSM state enum {IDLE, MUL, DIV, FIX};
  - divide-by-zero result constants.
- One sub-module, ex_md_iter:
  - iterative multiply/divide datapath and counter, plus the FSM;
  - start/flush in, done/busy/hi/lo out.
- The top holds the single-cycle ALU, output registers and HI/LO write arbitration.

Test Plan:
- add A=FFFFFFFF, B=1 -> next cycle out_valid=1, result 00000000. sra A=4, B=80000000 -> F8000000.
- mult A=FFFFFFFD (-3), B=5 -> out_busy for 33 cycles. out_md_done 34 cycles after acceptance with HI=FFFFFFFF, LO=FFFFFFF1. mflo then returns FFFFFFF1.
- div A=FFFFFFF9 (-7), B=2 -> LO=FFFFFFFD, HI=FFFFFFFF. divu A=7, B=0 -> LO=FFFFFFFF, HI=00000007.
- Issue add during busy mult -> ignored: no out_valid, mult result unaffected.
- Assert in_flush in iteration 10 of a div -> out_busy=0 next cycle, no out_md_done, HI/LO keep their prior values.
- Drop rst_n mid-mult and between edges -> outputs and HI/LO go to 0 immediately. A post-reset sltu A=1, B=2 returns 1.

Source files
------------

// File: rtl/alu_md_pkg.sv
// rtl/alu_md_pkg.sv - opcode map, FSM states and divide constants for ex_alu_md
package alu_md_pkg;

  localparam logic [2:0] GRP_ARITH  = 3'b000;
  localparam logic [2:0] GRP_LOGIC  = 3'b001;
  localparam logic [2:0] GRP_SHIFT  = 3'b010;
  localparam logic [2:0] GRP_CMP    = 3'b011;
  localparam logic [2:0] GRP_MULDIV = 3'b100;
  localparam logic [2:0] GRP_HILO   = 3'b101;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;
  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_LUI  = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;
  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_MFHI = 2'b00;
  localparam logic [1:0] OP_MFLO = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_e;

  // Divide by zero: quotient is all ones, remainder is the dividend itself.
  localparam logic DIV0_LO_BIT = 1'b1;

endpackage

// File: rtl/ex_md_iter.sv
// rtl/ex_md_iter.sv - iterative shift-add multiply / restoring divide with sequencing FSM
// HI/LO leave through a one-cycle write strobe in FIX; done pulses the following cycle.
module ex_md_iter
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             wr_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_e        state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opd_q, opd_d;
  logic             is_div_q, is_div_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d;
  logic             div0_q, div0_d, done_q, done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, addend, shifted, diff;
  logic [2*WIDTH-1:0] prod_fix;

  assign is_signed = ~op_i[0];
  assign a_mag     = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag     = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;
  assign sum       = {1'b0, acc_hi_q} + {1'b0, opd_q};
  assign addend    = acc_lo_q[0] ? sum : {1'b0, acc_hi_q};
  assign shifted   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign diff      = shifted - {1'b0, opd_q};
  assign prod_fix  = neg_p_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opd_q    <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opd_q    <= opd_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opd_d    = opd_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    wr_o     = 1'b0;
    hi_o     = acc_hi_q;
    lo_o     = acc_lo_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_d    = '0;
            acc_hi_d = '0;
            is_div_d = op_i[1];
            neg_p_d  = is_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            if (op_i[1]) begin
              state_d  = DIV;
              acc_lo_d = a_mag;
              opd_d    = b_mag;
              neg_r_d  = is_signed & a_i[WIDTH-1];
              div0_d   = (b_i == '0);
            end else begin
              state_d  = MUL;
              acc_lo_d = b_mag;
              opd_d    = a_mag;
              neg_r_d  = 1'b0;
              div0_d   = 1'b0;
            end
          end
        end
        MUL: begin
          acc_hi_d = addend[WIDTH:1];
          acc_lo_d = {addend[0], acc_lo_q[WIDTH-1:1]};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) state_d = FIX;
        end
        DIV: begin
          // Restore by simply keeping the shifted partial remainder when the trial goes negative.
          if (!diff[WIDTH]) begin
            acc_hi_d = diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = shifted[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) state_d = FIX;
        end
        FIX: begin
          wr_o    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          if (is_div_q) begin
            hi_o = neg_r_q ? -acc_hi_q : acc_hi_q;
            lo_o = div0_q ? {WIDTH{DIV0_LO_BIT}} : (neg_p_q ? -acc_lo_q : acc_lo_q);
          end else begin
            {hi_o, lo_o} = prod_fix;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_alu_md.sv
// rtl/ex_alu_md.sv - MIPS32 EX-stage unit: single-cycle ALU, HI/LO registers, iterative mul/div
module ex_alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_flush,
  input  logic [4:0]       in_ALUFun,
  input  logic [WIDTH-1:0] in_dataA,
  input  logic [WIDTH-1:0] in_dataB,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_alu_result,
  output logic             out_busy,
  output logic             out_md_done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  logic [2:0]       grp;
  logic [1:0]       op;
  logic [SHW-1:0]   shamt;
  logic             accept, md_start, md_wr;
  logic [WIDTH-1:0] md_hi, md_lo, alu_res;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;

  assign grp      = in_ALUFun[4:2];
  assign op       = in_ALUFun[1:0];
  assign shamt    = in_dataA[SHW-1:0];
  assign accept   = in_valid & ~out_busy & ~in_flush;
  assign md_start = accept & (grp == GRP_MULDIV);

  ex_md_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_md_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .flush_i (in_flush),
    .op_i    (op),
    .a_i     (in_dataA),
    .b_i     (in_dataB),
    .busy_o  (out_busy),
    .done_o  (out_md_done),
    .wr_o    (md_wr),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  always_comb begin
    alu_res = '0;
    case (grp)
      GRP_ARITH: begin
        if (op == OP_ADD) alu_res = in_dataA + in_dataB;
        else if (op == OP_SUB) alu_res = in_dataA - in_dataB;
      end
      GRP_LOGIC: begin
        case (op)
          OP_AND:  alu_res = in_dataA & in_dataB;
          OP_OR:   alu_res = in_dataA | in_dataB;
          OP_XOR:  alu_res = in_dataA ^ in_dataB;
          default: alu_res = ~(in_dataA | in_dataB);
        endcase
      end
      GRP_SHIFT: begin
        case (op)
          OP_SLL:  alu_res = in_dataB << shamt;
          OP_SRL:  alu_res = in_dataB >> shamt;
          OP_LUI:  alu_res = in_dataB << (WIDTH / 2);
          default: alu_res = $unsigned($signed(in_dataB) >>> shamt);
        endcase
      end
      GRP_CMP: begin
        if (op == OP_SLT) alu_res = {{(WIDTH-1){1'b0}}, $signed(in_dataA) < $signed(in_dataB)};
        else if (op == OP_SLTU) alu_res = {{(WIDTH-1){1'b0}}, in_dataA < in_dataB};
      end
      GRP_HILO: begin
        case (op)
          OP_MFHI: alu_res = hi_q;
          OP_MFLO: alu_res = lo_q;
          default: alu_res = in_dataA;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  assign valid_d  = accept & (grp != GRP_MULDIV);
  assign result_d = valid_d ? alu_res : result_q;

  // The engine only writes from FIX, which is busy, so it can never collide with mthi/mtlo.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_wr) begin
      hi_d = md_hi;
      lo_d = md_lo;
    end else if (accept && grp == GRP_HILO) begin
      if (op == OP_MTHI) hi_d = in_dataA;
      if (op == OP_MTLO) lo_d = in_dataA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_alu_result = result_q;
  assign out_hi         = hi_q;
  assign out_lo         = lo_q;

endmodule

// File: tb/tb_ex_alu_md.sv
// tb/tb_ex_alu_md.sv - self-checking bench for ex_alu_md against a behavioural model
module tb_ex_alu_md;
  localparam int W = 32;

  localparam logic [4:0] F_ADD  = 5'b00000, F_SUB   = 5'b00001;
  localparam logic [4:0] F_AND  = 5'b00100, F_OR    = 5'b00101, F_XOR  = 5'b00110, F_NOR  = 5'b00111;
  localparam logic [4:0] F_SLL  = 5'b01000, F_SRL   = 5'b01001, F_LUI  = 5'b01010, F_SRA  = 5'b01011;
  localparam logic [4:0] F_SLT  = 5'b01100, F_SLTU  = 5'b01101, F_CMP2 = 5'b01110;
  localparam logic [4:0] F_MULT = 5'b10000, F_MULTU = 5'b10001, F_DIV  = 5'b10010, F_DIVU = 5'b10011;
  localparam logic [4:0] F_MFHI = 5'b10100, F_MFLO  = 5'b10101, F_MTHI = 5'b10110, F_MTLO = 5'b10111;
  localparam logic [4:0] F_RSV  = 5'b11000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_flush = 1'b0;
  logic [4:0]   in_ALUFun = '0;
  logic [W-1:0] in_dataA = '0;
  logic [W-1:0] in_dataB = '0;
  logic         out_valid, out_busy, out_md_done;
  logic [W-1:0] out_alu_result, out_hi, out_lo;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  ex_alu_md #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_flush       (in_flush),
    .in_ALUFun      (in_ALUFun),
    .in_dataA       (in_dataA),
    .in_dataB       (in_dataB),
    .out_valid      (out_valid),
    .out_alu_result (out_alu_result),
    .out_busy       (out_busy),
    .out_md_done    (out_md_done),
    .out_hi         (out_hi),
    .out_lo         (out_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_result = '0, m_hi = '0, m_lo = '0, pend_hi = '0, pend_lo = '0;
  int          md_left = 0;

  function automatic logic [31:0] alu_ref(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
    case (f)
      F_ADD:          return a + b;
      F_SUB:          return a - b;
      F_AND:          return a & b;
      F_OR:           return a | b;
      F_XOR:          return a ^ b;
      F_NOR:          return ~(a | b);
      F_SLL:          return b << a[4:0];
      F_SRL:          return b >> a[4:0];
      F_LUI:          return {b[15:0], 16'h0000};
      F_SRA:          return 32'($signed(b) >>> a[4:0]);
      F_SLT:          return {31'b0, $signed(a) < $signed(b)};
      F_SLTU:         return {31'b0, a < b};
      F_MFHI:         return hi;
      F_MFLO:         return lo;
      F_MTHI, F_MTLO: return a;
      default:        return 32'h0;
    endcase
  endfunction

  task automatic md_ref(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    p = '0;
    hi = '0;
    lo = '0;
    case (f)
      F_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        hi = p[63:32];
        lo = p[31:0];
      end
      F_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      F_DIV: begin
        if (b == 32'h0) begin
          lo = 32'hFFFFFFFF;
          hi = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          lo = 32'h80000000;
          hi = 32'h0;
        end else begin
          lo = 32'(int'(a) / int'(b));
          hi = 32'(int'(a) % int'(b));
        end
      end
      default: begin
        if (b == 32'h0) begin
          lo = 32'hFFFFFFFF;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      m_result = '0; m_hi = '0; m_lo = '0; md_left = 0;
    end else begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (in_flush) begin
        md_left = 0;
      end else if (md_left > 0) begin
        md_left--;
        if (md_left == 0) begin
          m_hi = pend_hi;
          m_lo = pend_lo;
          m_done = 1'b1;
        end
      end else if (in_valid) begin
        if (in_ALUFun[4:2] == 3'b100) begin
          md_ref(in_ALUFun, in_dataA, in_dataB, pend_hi, pend_lo);
          md_left = W + 1;
        end else begin
          m_valid  = 1'b1;
          m_result = alu_ref(in_ALUFun, in_dataA, in_dataB, m_hi, m_lo);
          if (in_ALUFun == F_MTHI) m_hi = in_dataA;
          if (in_ALUFun == F_MTLO) m_lo = in_dataA;
        end
      end
      m_busy = (md_left > 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cyc_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) chk("cyc_result", out_alu_result, m_result);
      chk("cyc_busy", 32'(out_busy), 32'(m_busy));
      chk("cyc_md_done", 32'(out_md_done), 32'(m_done));
      chk("cyc_hi", out_hi, m_hi);
      chk("cyc_lo", out_lo, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct packed {logic [4:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] e;} vec_t;
  typedef struct packed {logic [4:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] hi; logic [31:0] lo;} md_t;
  vec_t vecs [17];
  md_t  mds  [6];

  task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_ALUFun = f; in_dataA = a; in_dataB = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_md(input int inj_at, output int done_at, output int busy_n);
    done_at = 0;
    busy_n = 0;
    for (int k = 1; k <= 60; k++) begin
      if (out_busy) busy_n++;
      if (out_md_done) begin
        done_at = k;
        break;
      end
      if (inj_at != 0 && k == inj_at + 1) chk("busy_issue_ignored", 32'(out_valid), 32'h0);
      in_valid = (k == inj_at);
      if (k == inj_at) begin
        in_ALUFun = F_ADD; in_dataA = 32'h1; in_dataB = 32'h1;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at, busy_n, done_n;
    vecs[0]  = '{F_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[1]  = '{F_SRA,  32'h00000004, 32'h80000000, 32'hF8000000};
    vecs[2]  = '{F_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    vecs[3]  = '{F_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[4]  = '{F_OR,   32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0};
    vecs[5]  = '{F_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
    vecs[6]  = '{F_NOR,  32'h00000000, 32'h0F0F0F0F, 32'hF0F0F0F0};
    vecs[7]  = '{F_SLL,  32'h0000003F, 32'h00000001, 32'h80000000};
    vecs[8]  = '{F_SRL,  32'h00000004, 32'h80000000, 32'h08000000};
    vecs[9]  = '{F_LUI,  32'h00000000, 32'h00001234, 32'h12340000};
    vecs[10] = '{F_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[11] = '{F_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[12] = '{F_CMP2, 32'h00000001, 32'h00000002, 32'h00000000};
    vecs[13] = '{F_RSV,  32'h00000005, 32'h00000005, 32'h00000000};
    vecs[14] = '{F_MTHI, 32'h12345678, 32'h00000000, 32'h12345678};
    vecs[15] = '{F_MTLO, 32'h9ABCDEF0, 32'h00000000, 32'h9ABCDEF0};
    vecs[16] = '{F_MFHI, 32'h00000000, 32'h00000000, 32'h12345678};

    mds[0] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    mds[1] = '{F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    mds[2] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    mds[3] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    mds[4] = '{F_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    mds[5] = '{F_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};

    tick();
    chk_en = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(out_busy), 32'h0);
    chk("rst_hi", out_hi, 32'h0);
    chk("rst_lo", out_lo, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("vec%0d_result", i), out_alu_result, vecs[i].e);
    end

    issue(F_MULT, 32'hFFFFFFFD, 32'h00000005);
    wait_md(5, done_at, busy_n);
    chk("mult_latency", 32'(done_at), 32'd34);
    chk("mult_busy_cycles", 32'(busy_n), 32'd33);
    chk("mult_hi", out_hi, 32'hFFFFFFFF);
    chk("mult_lo", out_lo, 32'hFFFFFFF1);
    tick();
    chk("md_done_one_cycle", 32'(out_md_done), 32'h0);
    issue(F_MFLO, 32'h0, 32'h0);
    chk("mflo_after_mult", out_alu_result, 32'hFFFFFFF1);

    foreach (mds[i]) begin
      issue(mds[i].f, mds[i].a, mds[i].b);
      wait_md(0, done_at, busy_n);
      chk($sformatf("md%0d_latency", i), 32'(done_at), 32'd34);
      chk($sformatf("md%0d_hi", i), out_hi, mds[i].hi);
      chk($sformatf("md%0d_lo", i), out_lo, mds[i].lo);
    end

    issue(F_DIV, 32'h00000064, 32'h00000007);
    repeat (9) tick();
    in_flush = 1'b1; in_valid = 1'b1; in_ALUFun = F_ADD; in_dataA = 32'h1; in_dataB = 32'h1;
    tick();
    in_flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", 32'(out_busy), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_hi", out_hi, 32'hFFFFFFF0);
    chk("flush_lo", out_lo, 32'hFFFFFFFF);
    done_n = 0;
    repeat (40) begin
      if (out_md_done) done_n++;
      tick();
    end
    chk("flush_no_done", 32'(done_n), 32'h0);

    issue(F_DIVU, 32'd1003, 32'd10);
    wait_md(0, done_at, busy_n);
    chk("post_flush_hi", out_hi, 32'h00000003);
    chk("post_flush_lo", out_lo, 32'h00000064);

    issue(F_MULTU, 32'h3, 32'h5);
    repeat (5) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(out_busy), 32'h0);
    chk("rstmid_valid", 32'(out_valid), 32'h0);
    chk("rstmid_done", 32'(out_md_done), 32'h0);
    chk("rstmid_hi", out_hi, 32'h0);
    chk("rstmid_lo", out_lo, 32'h0);
    chk("rstmid_result", out_alu_result, 32'h0);
    tick();
    rst_n = 1'b1;
    issue(F_SLTU, 32'h1, 32'h2);
    chk("post_rst_sltu_valid", 32'(out_valid), 32'h1);
    chk("post_rst_sltu", out_alu_result, 32'h1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
